// File: rtl/game_pkg.sv
// Shared game constants and the FSM encoding used by the bird, wall and collision controllers.
// The BCD helper keeps the score saturation rule in one place.
package game_pkg;

   localparam int SCREEN_W   = 160;
   localparam int SCREEN_H   = 120;
   localparam int BIRD_X_DEF = 40;
   localparam int BIRD_W_DEF = 4;
   localparam int BIRD_H_DEF = 4;
   localparam int WALL_W_DEF = 8;
   localparam int GAP_H_DEF  = 32;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ARMED = 2'b01,
      ST_HIT   = 2'b10
   } game_state_e;

   // Two-digit BCD increment that sticks at 99.
   function automatic logic [7:0] bcd_inc_sat(input logic [3:0] tens, input logic [3:0] ones);
      logic [7:0] v_res;
      if (tens == 4'd9 && ones == 4'd9)
         v_res = {tens, ones};
      else if (ones == 4'd9)
         v_res = {tens + 4'd1, 4'd0};
      else
         v_res = {tens, ones + 4'd1};
      return v_res;
   endfunction

endpackage

// File: rtl/collision_score_if.sv
// Game-side bus of the collision monitor: control/position inputs and hit/score outputs.
interface collision_score_if;

   logic       go;
   logic       frame_tick;
   logic [6:0] bird_y;
   logic [7:0] wall_x;
   logic [6:0] gap_y;
   logic       collision;
   logic       hit_pulse;
   logic [3:0] score_ones;
   logic [3:0] score_tens;

   modport master (
      output go, frame_tick, bird_y, wall_x, gap_y,
      input  collision, hit_pulse, score_ones, score_tens
   );

   modport slave (
      input  go, frame_tick, bird_y, wall_x, gap_y,
      output collision, hit_pulse, score_ones, score_tens
   );

endinterface

// File: rtl/collision_score_bcd_counter2.sv
// Two-digit BCD score counter; clear has priority over increment, count saturates at 99.
module bcd_counter2
   import game_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_clr,
   input  logic       i_inc,
   output logic [3:0] o_ones,
   output logic [3:0] o_tens
);

   logic [3:0] r_ones;
   logic [3:0] r_tens;
   logic [7:0] w_next;

   assign w_next = bcd_inc_sat(r_tens, r_ones);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ones <= 4'd0;
         r_tens <= 4'd0;
      end else if (i_clr) begin
         r_ones <= 4'd0;
         r_tens <= 4'd0;
      end else if (i_inc) begin
         r_tens <= w_next[7:4];
         r_ones <= w_next[3:0];
      end
   end

   assign o_ones = r_ones;
   assign o_tens = r_tens;

endmodule

// File: rtl/collision_score.sv
// Collision/score monitor: samples positions per frame tick, tests wall and edge overlap,
// latches a hit until go, and scores each cleared wall.
//   state    | meaning
//   ST_IDLE  | waiting for go, ticks ignored
//   ST_ARMED | game running, each tick evaluated through a 2-stage pipe
//   ST_HIT   | collision latched, score frozen until go
module collision_score
   import game_pkg::*;
#(
   parameter int BIRD_X   = BIRD_X_DEF,
   parameter int BIRD_W   = BIRD_W_DEF,
   parameter int BIRD_H   = BIRD_H_DEF,
   parameter int WALL_W   = WALL_W_DEF,
   parameter int GAP_H    = GAP_H_DEF,
   parameter int SCREEN_H = game_pkg::SCREEN_H
)
(
   input  logic              clk,
   input  logic              resetn,
   collision_score_if.slave  bus
);

   localparam logic [8:0] C_BIRD_L   = 9'(BIRD_X);
   localparam logic [8:0] C_BIRD_R   = 9'(BIRD_X + BIRD_W);
   localparam logic [8:0] C_BIRD_H   = 9'(BIRD_H);
   localparam logic [8:0] C_WALL_W   = 9'(WALL_W);
   localparam logic [8:0] C_GAP_H    = 9'(GAP_H);
   localparam logic [8:0] C_SCREEN_H = 9'(SCREEN_H);

   game_state_e r_state;
   game_state_e w_state_nxt;

   logic       r_go_d;
   logic       r_s1_valid;
   logic [6:0] r_s1_bird_y;
   logic [7:0] r_s1_wall_x;
   logic [6:0] r_s1_gap_y;
   logic       r_passed;
   logic       r_hit_pulse;

   logic       w_go_rise;
   logic       w_eval;
   logic [8:0] w_bird9;
   logic [8:0] w_wall9;
   logic [8:0] w_gap9;
   logic       w_h_overlap;
   logic       w_wall_hit;
   logic       w_edge_hit;
   logic       w_any_hit;
   logic       w_pass;
   logic       w_pass_clr;

   logic       w_s1_load;
   logic       w_passed_nxt;
   logic       w_hit_set;
   logic       w_score_clr;
   logic       w_score_inc;
   logic [3:0] w_score_ones;
   logic [3:0] w_score_tens;

   assign w_go_rise = bus.go & ~r_go_d;
   assign w_eval    = r_s1_valid & (r_state == ST_ARMED);

   // Everything is compared 9 bits wide so wall_x + WALL_W never wraps.
   assign w_bird9 = {2'b00, r_s1_bird_y};
   assign w_wall9 = {1'b0, r_s1_wall_x};
   assign w_gap9  = {2'b00, r_s1_gap_y};

   assign w_h_overlap = (w_wall9 < C_BIRD_R) && ((w_wall9 + C_WALL_W) > C_BIRD_L);
   assign w_wall_hit  = w_h_overlap &&
                        ((w_bird9 < w_gap9) || ((w_bird9 + C_BIRD_H) > (w_gap9 + C_GAP_H)));
   assign w_edge_hit  = (w_bird9 == 9'd0) || ((w_bird9 + C_BIRD_H) >= C_SCREEN_H);
   assign w_any_hit   = w_wall_hit | w_edge_hit;
   assign w_pass      = ((w_wall9 + C_WALL_W) <= C_BIRD_L) && !r_passed;
   assign w_pass_clr  = w_wall9 > C_BIRD_R;

   always_comb begin
      w_state_nxt  = r_state;
      w_s1_load    = 1'b0;
      w_passed_nxt = r_passed;
      w_hit_set    = 1'b0;
      w_score_clr  = 1'b0;
      w_score_inc  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_go_rise) begin
               w_state_nxt  = ST_ARMED;
               w_score_clr  = 1'b1;
               w_passed_nxt = 1'b0;
            end
         end
         ST_ARMED: begin
            w_s1_load = bus.frame_tick;
            if (w_eval) begin
               // A hit overrides a simultaneous pass and flushes the tick behind it.
               if (w_any_hit) begin
                  w_state_nxt = ST_HIT;
                  w_hit_set   = 1'b1;
                  w_s1_load   = 1'b0;
               end else if (w_pass) begin
                  w_score_inc  = 1'b1;
                  w_passed_nxt = 1'b1;
               end else if (w_pass_clr) begin
                  w_passed_nxt = 1'b0;
               end
            end
         end
         ST_HIT: begin
            if (w_go_rise) begin
               w_state_nxt  = ST_ARMED;
               w_score_clr  = 1'b1;
               w_passed_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state     <= ST_IDLE;
         r_go_d      <= 1'b0;
         r_s1_valid  <= 1'b0;
         r_s1_bird_y <= 7'd0;
         r_s1_wall_x <= 8'd0;
         r_s1_gap_y  <= 7'd0;
         r_passed    <= 1'b0;
         r_hit_pulse <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_go_d      <= bus.go;
         r_s1_valid  <= w_s1_load;
         r_passed    <= w_passed_nxt;
         r_hit_pulse <= w_hit_set;
         if (w_s1_load) begin
            r_s1_bird_y <= bus.bird_y;
            r_s1_wall_x <= bus.wall_x;
            r_s1_gap_y  <= bus.gap_y;
         end
      end
   end

   bcd_counter2 u_score (
      .clk    (clk),
      .rst_n  (resetn),
      .i_clr  (w_score_clr),
      .i_inc  (w_score_inc),
      .o_ones (w_score_ones),
      .o_tens (w_score_tens)
   );

   assign bus.collision  = (r_state == ST_HIT);
   assign bus.hit_pulse  = r_hit_pulse;
   assign bus.score_ones = w_score_ones;
   assign bus.score_tens = w_score_tens;

endmodule
